fsm_control_param: RTL and testbench

Parametrised control FSM for the router datapath, next generation of the five-FIFO control block. Supervises NUM_FIFO FIFOs, captures a packed threshold bank during initialisation and reports active/idle/error status. Extensions: arbitrary FIFO count and threshold width, programmable idle hysteresis, sticky per-FIFO error capture with a lowest-index error ID, and error recovery via `init` without a full reset.

---
 rtl/fsm_control_param_if.sv | 30 +++
 rtl/fsm_control_param.sv | 106 ++++++++++
 tb/tb_fsm_control_param.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fsm_control_param_if.sv
// rtl/fsm_control_param_if.sv - control/status bundle between router datapath and FIFO supervisor
// master drives requests and FIFO flags; slave (the supervisor) returns thresholds and status.
interface fsm_control_param_if #(
   parameter int NUM_FIFO = 5,
   parameter int UMB_W    = 4
);
   localparam int IDW = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

   logic                      init;
   logic [NUM_FIFO*UMB_W-1:0] umbrales_in;
   logic [NUM_FIFO-1:0]       FIFO_error;
   logic [NUM_FIFO-1:0]       FIFO_empty;
   logic [NUM_FIFO*UMB_W-1:0] umbrales_I;
   logic                      active_out;
   logic                      idle_out;
   logic                      error_out;
   logic [NUM_FIFO-1:0]       error_vec;
   logic [IDW-1:0]            error_id;
   logic [2:0]                state_out;

   modport master (
      output init, umbrales_in, FIFO_error, FIFO_empty,
      input  umbrales_I, active_out, idle_out, error_out, error_vec, error_id, state_out
   );

   modport slave (
      input  init, umbrales_in, FIFO_error, FIFO_empty,
      output umbrales_I, active_out, idle_out, error_out, error_vec, error_id, state_out
   );
endinterface

// File: rtl/fsm_control_param.sv
// rtl/fsm_control_param.sv - parametrised FIFO supervisor FSM with threshold capture and sticky errors
// States RESET/INIT/IDLE/ACTIVE/ERROR; all status outputs are decoded from registers only.
module fsm_control_param #(
   parameter int NUM_FIFO  = 5,
   parameter int UMB_W     = 4,
   parameter int IDLE_WAIT = 1
) (
   input logic                 clk,
   input logic                 reset,
   fsm_control_param_if.slave  bus
);
   localparam int IDW = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
   localparam int CW  = (IDLE_WAIT > 1) ? $clog2(IDLE_WAIT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_WAIT - 1);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_ACTIVE = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_nxt;
   logic [IDW-1:0]      low_id;
   logic [NUM_FIFO-1:0] vec;
   logic [IDW-1:0]      id;
   logic                err_any;
   logic                all_empty;

   assign err_any   = |bus.FIFO_error;
   assign all_empty = &bus.FIFO_empty;

   // Descending scan so the lowest set index is the last one written.
   always_comb begin
      low_id = '0;
      for (int i = NUM_FIFO - 1; i >= 0; i--) begin
         if (bus.FIFO_error[i]) low_id = IDW'(i);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         S_RESET: state_nxt = S_INIT;
         S_INIT: begin
            if (err_any)        state_nxt = S_ERROR;
            else if (!bus.init) state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (err_any)         state_nxt = S_ERROR;
            else if (bus.init)   state_nxt = S_INIT;
            else if (!all_empty) state_nxt = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (err_any)       state_nxt = S_ERROR;
            else if (bus.init) state_nxt = S_INIT;
            else if (all_empty) begin
               if (cnt == CNT_LAST) state_nxt = S_IDLE;
               else                 cnt_nxt   = cnt + 1'b1;
            end
         end
         S_ERROR: begin
            if (bus.init) state_nxt = S_INIT;
         end
         default: state_nxt = S_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_RESET;
         cnt            <= '0;
         vec            <= '0;
         id             <= '0;
         bus.umbrales_I <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == S_INIT) bus.umbrales_I <= bus.umbrales_in;
         // Recovery through init wins over a still-asserted error while in ERROR.
         if (state == S_ERROR) begin
            if (bus.init) begin
               vec <= '0;
               id  <= '0;
            end else begin
               vec <= vec | bus.FIFO_error;
            end
         end else if (state_nxt == S_ERROR) begin
            vec <= bus.FIFO_error;
            id  <= low_id;
         end
      end
   end

   assign bus.state_out  = state;
   assign bus.active_out = (state == S_ACTIVE);
   assign bus.idle_out   = (state == S_IDLE);
   assign bus.error_out  = (state == S_ERROR);
   assign bus.error_vec  = vec;
   assign bus.error_id   = id;
endmodule

// File: tb/tb_fsm_control_param.sv
// tb/tb_fsm_control_param.sv - scoreboard bench for fsm_control_param
// Driver pushes hand-computed expectations; monitor pops and compares each checkpoint.
module tb_fsm_control_param;
   localparam int NF = 5;
   localparam int UW = 4;

   localparam logic [2:0] RST = 3'd0, INI = 3'd1, IDL = 3'd2, ACT = 3'd3, ERR = 3'd4;

   typedef struct packed {
      logic [2:0]     st;
      logic [NF*UW-1:0] umb;
      logic [NF-1:0]  vec;
      logic [2:0]     id;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   exp_t  exp_q[$];
   string name_q[$];
   event  chk_ev;

   fsm_control_param_if #(.NUM_FIFO(NF), .UMB_W(UW)) bus ();

   fsm_control_param #(.NUM_FIFO(NF), .UMB_W(UW), .IDLE_WAIT(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string f, input logic [31:0] a, input logic [31:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s.%s actual=%0h required=%0h", nm, f, a, x);
      end
   endtask

   task automatic pop_check();
      exp_t  e;
      string nm;
      if (exp_q.size() == 0) return;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "state",  32'(bus.state_out),  32'(e.st));
      chk(nm, "active", 32'(bus.active_out), 32'(e.st == ACT));
      chk(nm, "idle",   32'(bus.idle_out),   32'(e.st == IDL));
      chk(nm, "error",  32'(bus.error_out),  32'(e.st == ERR));
      chk(nm, "umb",    32'(bus.umbrales_I), 32'(e.umb));
      chk(nm, "vec",    32'(bus.error_vec),  32'(e.vec));
      chk(nm, "id",     32'(bus.error_id),   32'(e.id));
   endtask

   always @(negedge clk) pop_check();
   always @(chk_ev) pop_check();

   task automatic expect_out(input string nm, input logic [2:0] st, input logic [19:0] umb,
                             input logic [4:0] vec, input logic [2:0] id);
      exp_t e;
      e.st = st; e.umb = umb; e.vec = vec; e.id = id;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Drive inputs just after a falling edge; expectation applies after the next rising edge.
   task automatic step(input string nm, input logic i, input logic [19:0] u, input logic [4:0] er,
                       input logic [4:0] em, input logic [2:0] st, input logic [19:0] umb,
                       input logic [4:0] vec, input logic [2:0] id);
      bus.init        = i;
      bus.umbrales_in = u;
      bus.FIFO_error  = er;
      bus.FIFO_empty  = em;
      expect_out(nm, st, umb, vec, id);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      step("rst_hold", 0, 20'h0, 5'h00, 5'h1F, RST, 20'h0, 5'h00, 3'd0);
      reset = 1'b0;
      step("to_init",  1, 20'hA5C3F, 5'h00, 5'h1F, INI, 20'h0,     5'h00, 3'd0);
      step("init_ld",  1, 20'hA5C3F, 5'h00, 5'h1F, INI, 20'hA5C3F, 5'h00, 3'd0);
      step("to_idle",  0, 20'hA5C3F, 5'h00, 5'h1F, IDL, 20'hA5C3F, 5'h00, 3'd0);
      step("idle_hold",0, 20'h00000, 5'h00, 5'h1F, IDL, 20'hA5C3F, 5'h00, 3'd0);
      step("to_act",   0, 20'h00000, 5'h00, 5'h1B, ACT, 20'hA5C3F, 5'h00, 3'd0);
      step("emp1",     0, 20'h00000, 5'h00, 5'h1F, ACT, 20'hA5C3F, 5'h00, 3'd0);
      step("restart",  0, 20'h00000, 5'h00, 5'h1B, ACT, 20'hA5C3F, 5'h00, 3'd0);
      step("emp1b",    0, 20'h00000, 5'h00, 5'h1F, ACT, 20'hA5C3F, 5'h00, 3'd0);
      step("emp2b",    0, 20'h00000, 5'h00, 5'h1F, ACT, 20'hA5C3F, 5'h00, 3'd0);
      step("emp3b",    0, 20'h00000, 5'h00, 5'h1F, IDL, 20'hA5C3F, 5'h00, 3'd0);
      step("re_act",   0, 20'h00000, 5'h00, 5'h1B, ACT, 20'hA5C3F, 5'h00, 3'd0);
      step("err_in",   0, 20'h00000, 5'h14, 5'h1F, ERR, 20'hA5C3F, 5'h14, 3'd2);
      step("err_hold", 0, 20'h00000, 5'h00, 5'h1F, ERR, 20'hA5C3F, 5'h14, 3'd2);
      step("err_stk",  0, 20'h00000, 5'h01, 5'h1F, ERR, 20'hA5C3F, 5'h15, 3'd2);
      step("recover",  1, 20'h12345, 5'h01, 5'h1F, INI, 20'hA5C3F, 5'h00, 3'd0);
      step("rec_ld",   1, 20'h12345, 5'h00, 5'h1F, INI, 20'h12345, 5'h00, 3'd0);
      step("rec_idle", 0, 20'h12345, 5'h00, 5'h1F, IDL, 20'h12345, 5'h00, 3'd0);
      step("act2",     0, 20'h00000, 5'h00, 5'h1B, ACT, 20'h12345, 5'h00, 3'd0);
      step("act2_e1",  0, 20'h00000, 5'h00, 5'h1F, ACT, 20'h12345, 5'h00, 3'd0);
      step("act2_e2",  0, 20'h00000, 5'h00, 5'h1F, ACT, 20'h12345, 5'h00, 3'd0);
      // Counter now at 2: reset lands between edges and must act immediately.
      reset = 1'b1;
      #1;
      expect_out("async_rst", RST, 20'h0, 5'h00, 3'd0);
      ->chk_ev;
      #1;
      step("rst_hold2", 0, 20'h00000, 5'h00, 5'h1F, RST, 20'h0, 5'h00, 3'd0);
      reset = 1'b0;
      step("init2",    1, 20'h0ABCD, 5'h00, 5'h1F, INI, 20'h00000, 5'h00, 3'd0);
      step("idle2",    0, 20'h0ABCD, 5'h00, 5'h1F, IDL, 20'h0ABCD, 5'h00, 3'd0);
      step("act3",     0, 20'h00000, 5'h00, 5'h1B, ACT, 20'h0ABCD, 5'h00, 3'd0);
      step("act3_e1",  0, 20'h00000, 5'h00, 5'h1F, ACT, 20'h0ABCD, 5'h00, 3'd0);
      step("act3_e2",  0, 20'h00000, 5'h00, 5'h1F, ACT, 20'h0ABCD, 5'h00, 3'd0);
      step("act3_e3",  0, 20'h00000, 5'h00, 5'h1F, IDL, 20'h0ABCD, 5'h00, 3'd0);
      step("prio",     1, 20'h00000, 5'h08, 5'h1F, ERR, 20'h0ABCD, 5'h08, 3'd3);
      step("prio_rec", 1, 20'h00000, 5'h08, 5'h1F, INI, 20'h0ABCD, 5'h00, 3'd0);
      step("init_err", 0, 20'h00000, 5'h03, 5'h1F, ERR, 20'h00000, 5'h03, 3'd0);
      chk("drain", "qsize", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
